char_input_buffer: RTL
======================

# char_input_buffer

Upstream feeder for `video_terminal`. It receives characters from the Apple-1 breadboard PIA port B through the asynchronous `rd[7:1]`/`da` pins, synchronizes them and queues them in a small FIFO. It then replays them to the terminal through a `rd`/`da`/`rda_n` handshake, so the 6502 never stalls on terminal scroll or clear time. It also drives the PB7 ready line (`ext_rda`) back to the PIA.

## Interface
- `DEPTH`, 16: FIFO entries, power of 2, ≥4.
- `SYNC_STAGES`, 2: synchronizer flops on `ext_rd`/`ext_da`, ≥2.
- `ACK_TIMEOUT`, 1024: clocks to wait for terminal acceptance before abandoning a character, ≥2.
- `clk` input 1: system clock (locked clock-generator output).
- `rst_n` input 1: reset, asynchronous, active-low.
- `ext_rd` input 7 (`[7:1]`): character from PIA PB6..PB0, asynchronous.
- `ext_da` input 1: data-available strobe from PIA CB2, asynchronous, active-high.
- `ext_rda` output 1: ready for data to PIA PB7, registered, high means space available.
- `clr` input 1: synchronous flush, already debounced/synchronized.
- `term_rd` output 7 (`[7:1]`): character to `video_terminal`, registered.
- `term_da` output 1: data-available to terminal, registered.
- `term_rda_n` input 1: terminal ready, active-low, synchronous to `clk`.
- `level` output `$clog2(DEPTH)+1`: FIFO occupancy.
- `overflow` output 1: sticky, a character was dropped on a full FIFO.
- `timeout` output 1: sticky, a character was abandoned after `ACK_TIMEOUT`.

## Operation
- **Input synchronization**
  - `ext_da` and `ext_rd` pass through `SYNC_STAGES` flops. `da_prev` holds the last synced `ext_da`.
  - The sync flops reset to 0. `da_prev` resets to 1, so `ext_da` already high at reset release is not captured.
  - A capture event occurs when synced `da` is 1 and `da_prev` is 0. The synced `ext_rd` is captured on that cycle.
  - The PIA guarantees `ext_rd` is stable ≥`SYNC_STAGES`+1 clocks before `ext_da` rises and while it is high.
- **Push**
  - On a capture event, the character is written if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise the character is dropped and `overflow` is set.
- **`ext_rda`**: registered `level_next < DEPTH`.
- **Pop FSM**
  - `IDLE`: `term_da`=0. If the FIFO is not empty and `term_rda_n`=0, load the head into `term_rd`, pop, clear the timer and go to `PRESENT`.
  - `PRESENT`: `term_da`=1 and `term_rd` is held.
    - If `term_rda_n`=1 (accepted), go to `RELEASE`.
    - Else, if timer = `ACK_TIMEOUT`-1, set `timeout` and go to `RELEASE`.
    - Else, increment the timer.
  - `RELEASE`: `term_da`=0 for exactly one cycle, then go to `IDLE`. This guarantees `term_da` low for ≥1 clock between characters.
- **FIFO**
  - Binary read/write pointers of width `$clog2(DEPTH)`, which wrap naturally.
  - `level` = writes − reads, range 0..`DEPTH`.
  - Push and pop in the same cycle leave `level` unchanged.
- **`clr`**
  - Resets the pointers and `level` to 0, the FSM to `IDLE`, `term_da` to 0, and clears `overflow` and `timeout`.
  - Takes priority over push, pop and the FSM in the same cycle.
  - A capture event coincident with `clr` is discarded.
  - `term_rd` keeps its value.
- **Reset mid-operation**: the asynchronous reset abandons any presented character immediately. All state returns to reset values.

## Timing
- Reset values: `ext_rda`=0, `term_rd`=0, `term_da`=0, `level`=0, `overflow`=0, `timeout`=0, FSM in `IDLE`.
- `ext_rda` rises on the first clock edge after `rst_n` deasserts.
- Pin to FIFO: a rising edge of `ext_da` is written on edge `SYNC_STAGES`+1. `level` increments on that same edge.
- `ext_rda` reflects the new `level` one clock after the write.
- Empty FIFO with terminal ready: `term_da` rises 1 clock after the FIFO write, so pin-to-`term_da` is `SYNC_STAGES`+2 clocks.
- Minimum character period to the terminal is 3 clocks (`IDLE`→`PRESENT`→`RELEASE`), given an immediate accept.
- `term_rd` is stable from the `IDLE`→`PRESENT` edge through the end of `RELEASE`.

## Test plan
- **Reset with `ext_da` held high**: release `rst_n` → no capture, `level`=0, `ext_rda`=1 after 1 clock.
- **Single character**: write 0x41 on `ext_rd`, pulse `ext_da`, terminal ready → `term_rd`=0x41 and `term_da`=1 at `SYNC_STAGES`+2 clocks. Raise `term_rda_n` → `term_da`=0 on the next clock.
- **Backpressure and overflow**: hold `term_rda_n`=1 and send `DEPTH`+1 characters 0x01.. → `level`=`DEPTH`, `ext_rda`=0, `overflow`=1. Then release `term_rda_n` → 0x01..0x10 drain in order and the extra character is absent.
- **Acceptance timeout**: keep `term_rda_n`=0 through `PRESENT` → `term_da` drops after `ACK_TIMEOUT` clocks, `timeout`=1, next character presented.
- **Simultaneous push and pop at full**: with `level`=`DEPTH`, a capture lands on the same clock as a pop → character accepted, `level` stays `DEPTH`, `overflow`=0.
- **`clr` during `PRESENT` with `level`=5**: → `term_da`=0, `level`=0, flags cleared, `ext_rda`=1 on the next clock.

Source files
------------

// File: rtl/char_input_buffer.sv
// Character queue between the Apple-1 PIA port B and video_terminal: synchronizes
// the asynchronous rd/da pins, buffers characters in a FIFO and replays them with a timeout.
module char_input_buffer #(
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [7:1]              ext_rd,
    input  logic                    ext_da,
    output logic                    ext_rda,
    input  logic                    clr,
    output logic [7:1]              term_rd,
    output logic                    term_da,
    input  logic                    term_rda_n,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    overflow,
    output logic                    timeout
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT);
    localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer and rising-edge detector
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] da_sync;
    logic [SYNC_STAGES-1:0] sync_primed;
    logic [7:1]             rd_sync [SYNC_STAGES];
    logic                   da_prev;
    logic                   da_synced;
    logic [7:1]             rd_synced;
    logic                   capture;

    assign da_synced = da_sync[SYNC_STAGES-1];
    assign rd_synced = rd_sync[SYNC_STAGES-1];

    // da_prev stays at 1 until the synchronizer holds real samples, so the
    // 0 -> 1 transition of a pin already high at reset release is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            da_sync     <= '0;
            sync_primed <= '0;
            da_prev     <= 1'b1;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                rd_sync[i] <= '0;
            end
        end else begin
            da_sync     <= {da_sync[SYNC_STAGES-2:0], ext_da};
            sync_primed <= {sync_primed[SYNC_STAGES-2:0], 1'b1};
            rd_sync[0]  <= ext_rd;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                rd_sync[i] <= rd_sync[i-1];
            end
            if (sync_primed[SYNC_STAGES-1]) begin
                da_prev <= da_synced;
            end
        end
    end

    assign capture = da_synced & ~da_prev;

    // ------------------------------------------------------------------
    // FIFO storage and occupancy
    // ------------------------------------------------------------------
    logic [7:1]    mem [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          drop;

    assign full  = (level_q == LEVEL_FULL);
    assign empty = (level_q == '0);

    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push = capture & ~clr & (~full | pop);
    assign drop = capture & ~clr & ~push;

    always_comb begin
        level_d = level_q;
        if (clr) begin
            level_d = '0;
        end else begin
            case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= rd_synced;
        end
    end

    // ------------------------------------------------------------------
    // Terminal handshake: in IDLE a character is taken while term_rda_n is
    // low; term_da then stays high until term_rda_n goes high (accepted) or
    // the timer expires, followed by one forced low cycle in RELEASE.
    // ------------------------------------------------------------------
    state_t        state_q;
    state_t        state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          timeout_set;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        pop         = 1'b0;
        timeout_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && !term_rda_n) begin
                    pop     = 1'b1;
                    timer_d = '0;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (term_rda_n) begin
                    state_d = RELEASE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_set = 1'b1;
                    state_d     = RELEASE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (clr) begin
            state_d     = IDLE;
            pop         = 1'b0;
            timeout_set = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------
    logic       ext_rda_q;
    logic [7:1] term_rd_q;
    logic       term_da_q;
    logic       overflow_q;
    logic       timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            ext_rda_q  <= 1'b0;
            state_q    <= IDLE;
            timer_q    <= '0;
            term_rd_q  <= '0;
            term_da_q  <= 1'b0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (clr) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (push) begin
                    wptr_q <= wptr_q + PW'(1);
                end
                if (pop) begin
                    rptr_q <= rptr_q + PW'(1);
                end
            end
            level_q   <= level_d;
            ext_rda_q <= (level_d < LEVEL_FULL);
            state_q   <= state_d;
            timer_q   <= timer_d;
            term_da_q <= (state_d == PRESENT);
            if (pop) begin
                term_rd_q <= mem[rptr_q];
            end
            if (clr) begin
                overflow_q <= 1'b0;
                timeout_q  <= 1'b0;
            end else begin
                if (drop) begin
                    overflow_q <= 1'b1;
                end
                if (timeout_set) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    assign ext_rda  = ext_rda_q;
    assign term_rd  = term_rd_q;
    assign term_da  = term_da_q;
    assign level    = level_q;
    assign overflow = overflow_q;
    assign timeout  = timeout_q;

endmodule
